// File: rtl/phase_sequencer_pkg.sv
// Shared types for the instruction phase sequencer and the phase-decoding controller.
package phase_sequencer_pkg;

  typedef enum logic [1:0] {
    PH_FETCH   = 2'd0,
    PH_DECODE  = 2'd1,
    PH_EXECUTE = 2'd2,
    PH_UPDATE  = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WAIT,
    ST_UPDATE
  } seq_state_e;

  // WAIT shows as EXECUTE to the controller; HALT shows FETCH with PH_VALID low
  function automatic phase_e phase_of(input seq_state_e s);
    case (s)
      ST_DECODE: return PH_DECODE;
      ST_EXEC,
      ST_WAIT:   return PH_EXECUTE;
      ST_UPDATE: return PH_UPDATE;
      default:   return PH_FETCH;
    endcase
  endfunction

  function automatic int timer_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// Memory wait-state timer: loadable down-counter whose expiry is held off until RDY=1.
module wait_timer
  import phase_sequencer_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic active,
  input  logic rdy,
  output logic expired
);

  localparam int TW = timer_width(WAIT_CYCLES);
  // Loading WAIT_CYCLES-1 makes the count reach zero in the last fixed wait cycle
  localparam logic [TW-1:0] LOAD_VAL = TW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (active && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign expired = (count == '0) && rdy;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer with run/halt/step control, wait states and retire counter.
// Optional breakpoint support is built when BREAKPOINT_EN is defined.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 16,
  parameter int PC_W        = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             MEM_ACC,
  input  logic             RDY,
  input  logic [PC_W-1:0]  PC,
  input  logic [PC_W-1:0]  BP_ADDR,
  input  logic             BP_ARM,
  output logic [1:0]       PH,
  output logic             PH_VALID,
  output logic             HALTED,
  output logic             INSTR_DONE,
  output logic [CNT_W-1:0] INSTR_CNT,
  output logic             BP_HIT
);

  seq_state_e state, state_next;
  logic step_flag, step_next;
  logic timer_load, timer_expired;
  logic retire, resume, bp_trip;

  wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_timer (
    .clk     (CLK),
    .rst     (RST),
    .load    (timer_load),
    .active  (state == ST_WAIT),
    .rdy     (RDY),
    .expired (timer_expired)
  );

  always_comb begin
    state_next = state;
    step_next  = step_flag;
    timer_load = 1'b0;
    retire     = 1'b0;
    resume     = 1'b0;
    case (state)
      ST_HALT: begin
        if (RUN || STEP) begin
          state_next = ST_FETCH;
          step_next  = STEP && !RUN;
          resume     = 1'b1;
        end
      end
      ST_FETCH: begin
        if (bp_trip) begin
          state_next = ST_HALT;
          step_next  = 1'b0;
        end else begin
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        if (MEM_ACC && ((WAIT_CYCLES > 0) || !RDY)) begin
          state_next = ST_WAIT;
          timer_load = 1'b1;
        end else begin
          state_next = ST_UPDATE;
        end
      end
      ST_WAIT: begin
        if (timer_expired) state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        retire     = 1'b1;
        step_next  = 1'b0;
        state_next = (RUN && !step_flag) ? ST_FETCH : ST_HALT;
      end
      default: state_next = ST_HALT;
    endcase
  end

  // Phase outputs are registered from the next state so they align with the state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_HALT;
      step_flag  <= 1'b0;
      PH         <= PH_FETCH;
      PH_VALID   <= 1'b0;
      HALTED     <= 1'b1;
      INSTR_DONE <= 1'b0;
      INSTR_CNT  <= '0;
    end else begin
      state      <= state_next;
      step_flag  <= step_next;
      PH         <= phase_of(state_next);
      PH_VALID   <= (state_next != ST_HALT);
      HALTED     <= (state_next == ST_HALT);
      INSTR_DONE <= retire;
      if (retire) INSTR_CNT <= INSTR_CNT + CNT_W'(1);
    end
  end

`ifdef BREAKPOINT_EN
  logic skip;

  // skip lets the resumed fetch at the breakpoint address proceed once
  assign bp_trip = (state == ST_FETCH) && BP_ARM && (PC == BP_ADDR) && !skip;

  always_ff @(posedge CLK) begin
    if (RST) begin
      skip   <= 1'b0;
      BP_HIT <= 1'b0;
    end else if (bp_trip) begin
      skip   <= 1'b1;
      BP_HIT <= 1'b1;
    end else begin
      if (resume) BP_HIT <= 1'b0;
      if (retire) skip <= 1'b0;
    end
  end
`else
  logic unused_bp;

  assign bp_trip   = 1'b0;
  assign BP_HIT    = 1'b0;
  assign unused_bp = ^{PC, BP_ADDR, BP_ARM, resume};
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: expected per-cycle outputs are queued as stimulus is driven.
// Breakpoint scenario runs only when BREAKPOINT_EN is defined.
module tb_phase_sequencer;

  localparam int WAIT_CYCLES = 2;
  localparam int CNT_W       = 4;
  localparam int PC_W        = 5;

  typedef struct packed {
    logic [1:0]       ph;
    logic             valid;
    logic             halted;
    logic             done;
    logic [CNT_W-1:0] cnt;
    logic             bp;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, run, step, mem_acc, rdy, bp_arm;
  logic [PC_W-1:0]  pc, bp_addr;
  logic [1:0]       ph;
  logic             ph_valid, halted, instr_done, bp_hit;
  logic [CNT_W-1:0] instr_cnt;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             pend_done = 1'b0;
  logic             exp_bp = 1'b0;
  int               num_checks = 0;
  int               num_fails = 0;
  int               cycle = 0;

  phase_sequencer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .CNT_W       (CNT_W),
    .PC_W        (PC_W)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .RUN        (run),
    .STEP       (step),
    .MEM_ACC    (mem_acc),
    .RDY        (rdy),
    .PC         (pc),
    .BP_ADDR    (bp_addr),
    .BP_ARM     (bp_arm),
    .PH         (ph),
    .PH_VALID   (ph_valid),
    .HALTED     (halted),
    .INSTR_DONE (instr_done),
    .INSTR_CNT  (instr_cnt),
    .BP_HIT     (bp_hit)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic m, input logic y);
    run = r; step = s; mem_acc = m; rdy = y;
  endtask

  // Advance one clock, then compare DUT outputs with the oldest queued expectation
  task automatic sample_and_compare();
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    e = exp_q.pop_front();
    checkOutput("PH",         32'(ph),         32'(e.ph));
    checkOutput("PH_VALID",   32'(ph_valid),   32'(e.valid));
    checkOutput("HALTED",     32'(halted),     32'(e.halted));
    checkOutput("INSTR_DONE", 32'(instr_done), 32'(e.done));
    checkOutput("INSTR_CNT",  32'(instr_cnt),  32'(e.cnt));
    checkOutput("BP_HIT",     32'(bp_hit),     32'(e.bp));
  endtask

  task automatic expect_cycle(input logic [1:0] exp_ph, input logic valid);
    exp_t e;
    e.ph = exp_ph; e.valid = valid; e.halted = !valid;
    e.done = pend_done; e.cnt = exp_cnt; e.bp = exp_bp;
    exp_q.push_back(e);
    pend_done = 1'b0;
    sample_and_compare();
  endtask

  task automatic expect_halt(input int n);
    for (int i = 0; i < n; i++) expect_cycle(2'd0, 1'b0);
  endtask

  // One full instruction; stall adds RDY=0 cycles after the fixed wait count
  task automatic run_instr(input logic mem, input int stall, input bit drop_run, input bit second_step);
    int nw;
    mem_acc = mem;
    rdy = (stall == 0);
    expect_cycle(2'd0, 1'b1);
    step = 1'b0;
    expect_cycle(2'd1, 1'b1);
    if (drop_run) run = 1'b0;
    if (second_step) step = 1'b1;
    expect_cycle(2'd2, 1'b1);
    step = 1'b0;
    nw = mem ? WAIT_CYCLES + stall : 0;
    for (int k = 1; k <= nw; k++) begin
      expect_cycle(2'd2, 1'b1);
      if (k == nw) rdy = 1'b1;
    end
    expect_cycle(2'd3, 1'b1);
    exp_cnt   = exp_cnt + CNT_W'(1);
    pend_done = 1'b1;
  endtask

  initial begin
    rst = 1'b1; pc = '0; bp_addr = '0; bp_arm = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    expect_halt(2);
    rst = 1'b0;
    expect_halt(1);

    // free-run, no memory access
    run = 1'b1;
    for (int i = 0; i < 3; i++) run_instr(1'b0, 0, 1'b0, 1'b0);

    // fixed wait states, then wait states plus RDY stall
    run_instr(1'b1, 0, 1'b0, 1'b0);
    run_instr(1'b1, 4, 1'b0, 1'b0);

    // RUN drops during DECODE: instruction completes, then halts
    run_instr(1'b0, 0, 1'b1, 1'b0);
    expect_halt(2);

    // single step, with a second STEP ignored mid-pass
    step = 1'b1;
    run_instr(1'b0, 0, 1'b0, 1'b1);
    expect_halt(2);

    // reset in the middle of WAIT
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    expect_cycle(2'd0, 1'b1);
    expect_cycle(2'd1, 1'b1);
    expect_cycle(2'd2, 1'b1);
    expect_cycle(2'd2, 1'b1);
    rst = 1'b1;
    exp_cnt = '0;
    pend_done = 1'b0;
    expect_halt(1);
    rst = 1'b0;
    rdy = 1'b1;

    // counter wraps from all-ones back to zero
    for (int i = 0; i < 16; i++) run_instr(1'b0, 0, (i == 15), 1'b0);
    expect_halt(2);

`ifdef BREAKPOINT_EN
    bp_addr = 5'd3;
    bp_arm  = 1'b1;
    run     = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pc = PC_W'(p);
      run_instr(1'b0, 0, 1'b0, 1'b0);
    end
    pc = 5'd3;
    expect_cycle(2'd0, 1'b1);
    run = 1'b0;
    exp_bp = 1'b1;
    expect_halt(2);
    run = 1'b1;
    exp_bp = 1'b0;
    run_instr(1'b0, 0, 1'b1, 1'b0);
    expect_halt(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
